// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause-22 MDIO management responder (PHY side).
// MDC and MDIO are oversampled on clk. Every frame decision is taken on the
// clk in which a synchronised MDC rising edge is seen. Register reads and
// writes are handed to the fabric through rd_req / wr_valid strobes.
module mdio_phy_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter bit         BCAST_WR_EN  = 1'b1,
  parameter int         PREAMBLE_MIN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        rd_req,
  output logic [4:0]  rd_addr,
  input  logic [15:0] rd_data,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic [7:0]  frame_err_cnt
);

  typedef enum logic [2:0] {
    IDLE, ST, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA
  } state_t;

  localparam logic [6:0] PRE_MIN = 7'(PREAMBLE_MIN);
  localparam logic [5:0] PRE_SAT = 6'd63;

  // Synchronisers and edge detector
  logic mdc_s1_reg, mdc_s2_reg, mdc_prev_reg;
  logic mdio_s1_reg, mdio_s2_reg;
  logic rise;
  logic bit_in;

  // Frame state
  state_t      state_reg;
  logic [5:0]  pre_cnt_reg;
  logic [4:0]  bit_cnt_reg;
  logic        op_first_reg;
  logic        is_read_reg;
  logic        match_reg;
  logic [4:0]  phyad_reg;
  logic [4:0]  regad_reg;
  logic [15:0] shift_reg;

  // Registered outputs
  logic        mdio_o_reg;
  logic        mdio_oe_reg;
  logic        rd_req_reg;
  logic [4:0]  rd_addr_reg;
  logic        wr_valid_reg;
  logic [4:0]  wr_addr_reg;
  logic [15:0] wr_data_reg;
  logic [7:0]  err_cnt_reg;

  // Values including the bit being sampled on this rise
  logic [4:0]  phyad_next;
  logic [4:0]  regad_next;
  logic [15:0] wr_word_next;
  logic        phy_match;
  logic        pre_ok;
  logic        frame_error;

  // Synchronisers idle high so a reset release never fakes an MDC edge
  always_ff @(posedge clk) begin
    if (reset) begin
      mdc_s1_reg   <= 1'b1;
      mdc_s2_reg   <= 1'b1;
      mdc_prev_reg <= 1'b1;
      mdio_s1_reg  <= 1'b1;
      mdio_s2_reg  <= 1'b1;
    end else begin
      mdc_s1_reg   <= mdc;
      mdc_s2_reg   <= mdc_s1_reg;
      mdc_prev_reg <= mdc_s2_reg;
      mdio_s1_reg  <= mdio_i;
      mdio_s2_reg  <= mdio_s1_reg;
    end
  end

  assign rise   = mdc_s2_reg & ~mdc_prev_reg;
  assign bit_in = mdio_s2_reg;

  assign phyad_next   = {phyad_reg[3:0], bit_in};
  assign regad_next   = {regad_reg[3:0], bit_in};
  assign wr_word_next = {shift_reg[14:0], bit_in};

  // Broadcast address 0 is honoured for writes only
  assign phy_match = (phyad_next == PHY_ADDR) |
                     (~is_read_reg & BCAST_WR_EN & (phyad_next == 5'd0));

  // A zero preamble requirement means any '0' in IDLE starts a frame
  generate
    if (PREAMBLE_MIN == 0) begin : g_no_preamble
      assign pre_ok = 1'b1;
    end else begin : g_preamble
      assign pre_ok = ({1'b0, pre_cnt_reg} >= PRE_MIN);
    end
  endgenerate

  // Malformed-frame detection: bad ST, reserved OP, or bad write turnaround
  always_comb begin
    frame_error = 1'b0;
    if (rise) begin
      case (state_reg)
        ST:      frame_error = ~bit_in;
        OP:      frame_error = (bit_cnt_reg == 5'd1) & (op_first_reg == bit_in);
        TA:      frame_error = ~is_read_reg &
                               ((bit_cnt_reg == 5'd0) ? ~bit_in : bit_in);
        default: frame_error = 1'b0;
      endcase
    end
  end

  // Frame FSM with registered pad and fabric outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      pre_cnt_reg  <= 6'd0;
      bit_cnt_reg  <= 5'd0;
      op_first_reg <= 1'b0;
      is_read_reg  <= 1'b0;
      match_reg    <= 1'b0;
      phyad_reg    <= 5'd0;
      regad_reg    <= 5'd0;
      shift_reg    <= 16'd0;
      mdio_o_reg   <= 1'b1;
      mdio_oe_reg  <= 1'b0;
      rd_req_reg   <= 1'b0;
      rd_addr_reg  <= 5'd0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= 5'd0;
      wr_data_reg  <= 16'd0;
      err_cnt_reg  <= 8'd0;
    end else begin
      rd_req_reg   <= 1'b0;
      wr_valid_reg <= 1'b0;
      if (rise) begin
        case (state_reg)
          IDLE: begin
            if (bit_in) begin
              if (pre_cnt_reg != PRE_SAT) pre_cnt_reg <= pre_cnt_reg + 6'd1;
            end else if (pre_ok) begin
              state_reg   <= ST;
              pre_cnt_reg <= 6'd0;
            end else begin
              pre_cnt_reg <= 6'd0;
            end
          end
          ST: begin
            state_reg   <= OP;
            bit_cnt_reg <= 5'd0;
          end
          OP: begin
            if (bit_cnt_reg == 5'd0) begin
              op_first_reg <= bit_in;
              bit_cnt_reg  <= 5'd1;
            end else begin
              is_read_reg <= op_first_reg;
              state_reg   <= PHYAD;
              bit_cnt_reg <= 5'd0;
            end
          end
          PHYAD: begin
            phyad_reg <= phyad_next;
            if (bit_cnt_reg == 5'd4) begin
              match_reg   <= phy_match;
              state_reg   <= REGAD;
              bit_cnt_reg <= 5'd0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end
          REGAD: begin
            regad_reg <= regad_next;
            if (bit_cnt_reg == 5'd4) begin
              if (is_read_reg & match_reg) begin
                rd_addr_reg <= regad_next;
                rd_req_reg  <= 1'b1;
              end
              state_reg   <= TA;
              bit_cnt_reg <= 5'd0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end
          TA: begin
            if (is_read_reg) begin
              // First TA rise: fabric data is ready, start driving TA bit 2
              if (match_reg) begin
                shift_reg   <= rd_data;
                mdio_oe_reg <= 1'b1;
                mdio_o_reg  <= 1'b0;
              end
              state_reg   <= RD_DATA;
              bit_cnt_reg <= 5'd0;
            end else if (bit_cnt_reg == 5'd0) begin
              bit_cnt_reg <= 5'd1;
            end else begin
              state_reg   <= WR_DATA;
              bit_cnt_reg <= 5'd0;
            end
          end
          RD_DATA: begin
            if (bit_cnt_reg == 5'd16) begin
              mdio_oe_reg <= 1'b0;
              mdio_o_reg  <= 1'b1;
              state_reg   <= IDLE;
              pre_cnt_reg <= 6'd0;
            end else begin
              if (match_reg) begin
                mdio_o_reg <= shift_reg[15];
                shift_reg  <= {shift_reg[14:0], 1'b0};
              end
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end
          WR_DATA: begin
            shift_reg <= wr_word_next;
            if (bit_cnt_reg == 5'd15) begin
              if (match_reg) begin
                wr_addr_reg  <= regad_reg;
                wr_data_reg  <= wr_word_next;
                wr_valid_reg <= 1'b1;
              end
              state_reg   <= IDLE;
              pre_cnt_reg <= 6'd0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end
          default: state_reg <= IDLE;
        endcase

        // A malformed frame overrides whatever the state decoded above
        if (frame_error) begin
          state_reg   <= IDLE;
          pre_cnt_reg <= 6'd0;
          if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
        end
      end
    end
  end

  assign mdio_o        = mdio_o_reg;
  assign mdio_oe       = mdio_oe_reg;
  assign rd_req        = rd_req_reg;
  assign rd_addr       = rd_addr_reg;
  assign wr_valid      = wr_valid_reg;
  assign wr_addr       = wr_addr_reg;
  assign wr_data       = wr_data_reg;
  assign busy          = (state_reg != IDLE);
  assign frame_err_cnt = err_cnt_reg;

endmodule
